div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 19 +
 rtl/div_step.sv | 22 ++
 rtl/div_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encodings and handshake constants.
package div_unit_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    FREE    = 2'b00,
    BY_ZERO = 2'b01,
    ON      = 2'b10,
    END     = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] i_rem,
  input  logic              i_bit,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_qbit
);

  logic [DATA_W:0] w_shifted;
  logic [DATA_W:0] w_diff;

  assign w_shifted = {i_rem, i_bit};
  assign w_diff    = w_shifted - {1'b0, i_divisor};

  // Shifted value is always below 2*divisor, so the borrow bit alone decides the quotient bit
  assign o_qbit = ~w_diff[DATA_W];
  assign o_rem  = o_qbit ? w_diff[DATA_W-1:0] : w_shifted[DATA_W-1:0];

endmodule

// File: rtl/div_unit.sv
// 32-cycle restoring divider (DIV/DIVU) with annul and divide-by-zero handling.
// Optional macro DIV_BYZERO_FLAG_EN adds the registered div_by_zero_o output.
module div_unit
  import div_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
`ifdef DIV_BYZERO_FLAG_EN
  ,
  output logic                  div_by_zero_o
`endif
);

  function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  div_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_divisor;
  logic              r_neg_q;
  logic              r_neg_r;

  logic signed [DATA_W-1:0] w_op1_s;
  logic signed [DATA_W-1:0] w_op2_s;
  logic              w_neg1;
  logic              w_neg2;
  logic              w_accept;
  logic [DATA_W-1:0] w_rem_next;
  logic [DATA_W-1:0] w_quo_next;
  logic              w_qbit;

  assign w_op1_s  = opdata1_i;
  assign w_op2_s  = opdata2_i;
  assign w_neg1   = signed_div_i & w_op1_s[DATA_W-1];
  assign w_neg2   = signed_div_i & w_op2_s[DATA_W-1];
  assign w_accept = (r_state == FREE) & (start_i == DivStart) & ~annul_i;

  assign stallreq_o = start_i & ~annul_i & (r_state != END);

  div_step u_step (
    .i_rem     (r_rem),
    .i_bit     (r_quo[DATA_W-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  assign w_quo_next = {r_quo[DATA_W-2:0], w_qbit};

  // Datapath: dividend magnitude shifts out of r_quo while quotient bits shift in
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rem     <= '0;
      r_quo     <= cond_neg(w_neg1, opdata1_i);
      r_divisor <= cond_neg(w_neg2, opdata2_i);
      r_neg_q   <= w_neg1 ^ w_neg2;
      r_neg_r   <= w_neg1;
    end else if (r_state == ON) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= FREE;
      r_cnt    <= '0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (r_state)
        FREE: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (w_accept) begin
            r_cnt   <= '0;
            r_state <= (opdata2_i == '0) ? BY_ZERO : ON;
          end
        end
        BY_ZERO: begin
          result_o <= '0;
          if (annul_i) begin
            r_state <= FREE;
            ready_o <= DivResultNotReady;
          end else begin
            r_state <= END;
            ready_o <= DivResultReady;
          end
        end
        ON: begin
          if (annul_i) begin
            r_state  <= FREE;
            r_cnt    <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_state  <= END;
            r_cnt    <= CNT_W'(DATA_W);
            result_o <= {cond_neg(r_neg_r, w_rem_next), cond_neg(r_neg_q, w_quo_next)};
            ready_o  <= DivResultReady;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        END: begin
          if (start_i == DivStop) begin
            r_state  <= FREE;
            r_cnt    <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
        default: begin
          r_state  <= FREE;
          r_cnt    <= '0;
          result_o <= '0;
          ready_o  <= DivResultNotReady;
        end
      endcase
    end
  end

`ifdef DIV_BYZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_by_zero_o <= 1'b0;
    end else if ((r_state == BY_ZERO) && !annul_i) begin
      div_by_zero_o <= 1'b1;
    end else if ((r_state == END) && (start_i == DivStop)) begin
      div_by_zero_o <= 1'b0;
    end
  end
`endif

endmodule
